// File: rtl/hart_scheduler_if.sv
// hart_scheduler_if: event/issue bundle between pipeline stages and the hart scheduler.
// HART_KILL_EN adds the kill request signals.
interface hart_scheduler_if #(
  parameter int HART_NUM  = 4,
  parameter int HART_ID_W = 2
);
  logic                 stall;
  logic                 id_hstart;
  logic [HART_ID_W-1:0] id_hs_id;
`ifdef HART_KILL_EN
  logic                 id_hkill;
  logic [HART_ID_W-1:0] id_hk_id;
`endif
  logic                 cache_miss;
  logic [HART_ID_W-1:0] cm_hart_id;
  logic                 cm_done;
  logic [HART_ID_W-1:0] cd_hart_id;
  logic [HART_ID_W-1:0] hart_id;
  logic                 issue_en;
  logic [HART_NUM-1:0]  hart_acti;
  logic [HART_NUM-1:0]  hart_pend;
  logic                 id_hidle;
  modport master (
    output stall, id_hstart, id_hs_id, cache_miss, cm_hart_id, cm_done, cd_hart_id,
`ifdef HART_KILL_EN
    output id_hkill, id_hk_id,
`endif
    input  hart_id, issue_en, hart_acti, hart_pend, id_hidle
  );
  modport slave (
    input  stall, id_hstart, id_hs_id, cache_miss, cm_hart_id, cm_done, cd_hart_id,
`ifdef HART_KILL_EN
    input  id_hkill, id_hk_id,
`endif
    output hart_id, issue_en, hart_acti, hart_pend, id_hidle
  );
endinterface

// File: rtl/hart_scheduler.sv
// hart_scheduler: round-robin fetch issue among active, non-pending harts.
// Define HART_KILL_EN to enable the hart kill request.
module hart_scheduler #(
  parameter int HART_NUM  = 4,
  parameter int HART_ID_W = 2
) (
  input logic              clk,
  input logic              reset,
  hart_scheduler_if.slave  bus
);
  localparam logic [HART_NUM-1:0] ONE = 1;
  logic [HART_NUM-1:0]  acti_q, acti_d, pend_q, pend_d;
  logic [HART_NUM-1:0]  start_v, kill_v, miss_v, done_v, elig;
  logic [HART_ID_W-1:0] hart_id_q, hart_id_d, sel, idx;
  logic                 issue_en_q, issue_en_d, found;
  always_comb begin
    kill_v = '0;
`ifdef HART_KILL_EN
    kill_v = bus.id_hkill ? ONE << bus.id_hk_id : '0;
`endif
    start_v = bus.id_hstart ? ONE << bus.id_hs_id : '0;
    miss_v = bus.cache_miss ? ONE << bus.cm_hart_id : '0;
    done_v = bus.cm_done ? ONE << bus.cd_hart_id : '0;
    acti_d = (acti_q | start_v) & ~kill_v;
    pend_d = ((pend_q & ~done_v) | miss_v) & ~kill_v;
    elig = acti_d & ~pend_d;
  end
  // search starts just after the last issued hart; k == HART_NUM wraps back to it
  always_comb begin
    found = 1'b0;
    sel = hart_id_q;
    idx = hart_id_q;
    for (int k = 1; k <= HART_NUM; k++) begin
      idx = hart_id_q + HART_ID_W'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
    hart_id_d = bus.stall ? hart_id_q : sel;
    issue_en_d = bus.stall ? issue_en_q : found;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acti_q <= ONE;
      pend_q <= '0;
      hart_id_q <= '0;
      issue_en_q <= 1'b0;
    end else begin
      acti_q <= acti_d;
      pend_q <= pend_d;
      hart_id_q <= hart_id_d;
      issue_en_q <= issue_en_d;
    end
  end
  assign bus.hart_id = hart_id_q;
  assign bus.issue_en = issue_en_q;
  assign bus.hart_acti = acti_q;
  assign bus.hart_pend = pend_q;
  assign bus.id_hidle = ~acti_q[bus.id_hs_id];
endmodule

// File: tb/tb_hart_scheduler.sv
// tb_hart_scheduler: directed stimulus, per-cycle compare against a behavioural model plus literal pins.
module tb_hart_scheduler;
  localparam int HN = 4;
  logic clk, reset;
  int n_cmp = 0, n_fail = 0;
  hart_scheduler_if #(.HART_NUM(HN), .HART_ID_W(2)) bus();
  hart_scheduler #(.HART_NUM(HN), .HART_ID_W(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  bit m_acti [HN];
  bit m_pend [HN];
  int m_last;
  bit m_iss;
  bit st, kl, ms, dn;
  always @(posedge clk) begin
    if (reset) begin
      for (int h = 0; h < HN; h++) begin
        m_acti[h] = (h == 0);
        m_pend[h] = 1'b0;
      end
      m_last = 0;
      m_iss = 1'b0;
    end else begin
      for (int h = 0; h < HN; h++) begin
        st = bus.id_hstart && int'(bus.id_hs_id) == h;
        kl = 1'b0;
`ifdef HART_KILL_EN
        kl = bus.id_hkill && int'(bus.id_hk_id) == h;
`endif
        ms = bus.cache_miss && int'(bus.cm_hart_id) == h;
        dn = bus.cm_done && int'(bus.cd_hart_id) == h;
        if (kl) begin
          m_acti[h] = 1'b0;
          m_pend[h] = 1'b0;
        end else begin
          if (st) m_acti[h] = 1'b1;
          if (ms) m_pend[h] = 1'b1;
          else if (dn) m_pend[h] = 1'b0;
        end
      end
      if (!bus.stall) begin
        m_iss = 1'b0;
        for (int s = 1; s <= HN; s++) begin
          if (!m_iss && m_acti[(m_last + s) % HN] && !m_pend[(m_last + s) % HN]) begin
            m_iss = 1'b1;
            m_last = (m_last + s) % HN;
          end
        end
      end
    end
  end
  always @(posedge clk) begin
    logic [HN-1:0] a, p;
    #1;
    for (int h = 0; h < HN; h++) begin
      a[h] = m_acti[h];
      p[h] = m_pend[h];
    end
    chk("model hart_id", bus.hart_id, m_last);
    chk("model issue_en", bus.issue_en, m_iss);
    chk("model hart_acti", bus.hart_acti, a);
    chk("model hart_pend", bus.hart_pend, p);
    chk("model id_hidle", bus.id_hidle, !m_acti[int'(bus.id_hs_id)]);
  end
  logic [6:0] tbl [10] = '{7'b0_0_00_1_01, 7'b0_0_00_1_11, 7'b1_1_01_0_00, 7'b1_0_00_0_00,
                           7'b0_1_11_1_00, 7'b0_0_00_1_10, 7'b0_1_00_0_00, 7'b1_1_10_0_00,
                           7'b0_0_00_0_00, 7'b0_0_00_0_00};
  initial begin
    reset = 1'b1;
    bus.stall = 0; bus.id_hstart = 0; bus.id_hs_id = 0;
    bus.cache_miss = 0; bus.cm_hart_id = 0; bus.cm_done = 0; bus.cd_hart_id = 0;
`ifdef HART_KILL_EN
    bus.id_hkill = 0; bus.id_hk_id = 0;
`endif
    repeat (2) @(negedge clk);
    chk("reset issue_en", bus.issue_en, 0);
    chk("reset hart_acti", bus.hart_acti, 4'b0001);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("boot issue_en", bus.issue_en, 1);
    chk("boot hart_id", bus.hart_id, 0);
    chk("boot hart_acti", bus.hart_acti, 4'b0001);
    chk("hidle hart0", bus.id_hidle, 0);
    bus.id_hs_id = 1;
    #1 chk("hidle hart1", bus.id_hidle, 1);
    for (int h = 1; h < HN; h++) begin
      bus.id_hstart = 1; bus.id_hs_id = 2'(h);
      @(negedge clk);
    end
    bus.id_hstart = 0;
    @(negedge clk);
    chk("rr start", bus.hart_id, 0);
    for (int k = 1; k < HN; k++) begin
      @(negedge clk);
      chk("rr order", bus.hart_id, k);
    end
    bus.cache_miss = 1; bus.cm_hart_id = 2;
    @(negedge clk);
    bus.cache_miss = 0;
    chk("miss pend", bus.hart_pend, 4'b0100);
    chk("wrap to 0", bus.hart_id, 0);
    @(negedge clk);
    @(negedge clk);
    chk("skip pending", bus.hart_id, 3);
    bus.cm_done = 1; bus.cd_hart_id = 2;
    @(negedge clk);
    bus.cm_done = 0;
    chk("done pend", bus.hart_pend, 4'b0000);
    repeat (2) @(negedge clk);
    chk("rejoin", bus.hart_id, 2);
    reset = 1; bus.id_hstart = 1; bus.id_hs_id = 3; bus.cache_miss = 1; bus.cm_hart_id = 1;
    @(negedge clk);
    chk("midreset acti", bus.hart_acti, 4'b0001);
    chk("midreset pend", bus.hart_pend, 4'b0000);
    chk("midreset issue", bus.issue_en, 0);
    reset = 0; bus.id_hstart = 0; bus.cache_miss = 0;
    @(negedge clk);
    chk("solo issue", bus.issue_en, 1);
    bus.cache_miss = 1; bus.cm_hart_id = 0;
    @(negedge clk);
    bus.cache_miss = 0;
    chk("solo miss bubble", bus.issue_en, 0);
    chk("solo miss hold", bus.hart_id, 0);
    repeat (2) @(negedge clk);
    chk("solo still bubble", bus.issue_en, 0);
    bus.cm_done = 1; bus.cd_hart_id = 0;
    @(negedge clk);
    bus.cm_done = 0;
    chk("solo resume", bus.issue_en, 1);
    chk("solo resume id", bus.hart_id, 0);
    bus.cache_miss = 1; bus.cm_hart_id = 1; bus.cm_done = 1; bus.cd_hart_id = 1;
    bus.id_hstart = 1; bus.id_hs_id = 3;
`ifdef HART_KILL_EN
    bus.id_hkill = 1; bus.id_hk_id = 3;
`endif
    @(negedge clk);
    bus.cache_miss = 0; bus.cm_done = 0; bus.id_hstart = 0;
`ifdef HART_KILL_EN
    bus.id_hkill = 0;
    chk("kill wins acti3", bus.hart_acti[3], 0);
`else
    chk("start acti3", bus.hart_acti[3], 1);
`endif
    chk("miss wins pend1", bus.hart_pend[1], 1);
    bus.cm_done = 1; bus.cd_hart_id = 1;
    @(negedge clk);
    bus.cm_done = 0;
`ifdef HART_KILL_EN
    bus.id_hstart = 1; bus.id_hs_id = 2;
    @(negedge clk);
    bus.id_hstart = 0; bus.id_hkill = 1; bus.id_hk_id = 2;
    @(negedge clk);
    bus.id_hkill = 0;
    chk("kill acti2", bus.hart_acti[2], 0);
`endif
    reset = 1;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    bus.stall = 1; bus.id_hstart = 1; bus.id_hs_id = 1;
    @(negedge clk);
    bus.id_hstart = 0;
    chk("stall acti", bus.hart_acti, 4'b0011);
    chk("stall hold id", bus.hart_id, 0);
    repeat (2) @(negedge clk);
    chk("stall hold issue", bus.issue_en, 1);
    bus.stall = 0;
    @(negedge clk);
    chk("post stall", bus.hart_id, 1);
    for (int h = 2; h < HN; h++) begin
      bus.id_hstart = 1; bus.id_hs_id = 2'(h);
      @(negedge clk);
    end
    bus.id_hstart = 0;
    foreach (tbl[i]) begin
      bus.stall = tbl[i][6];
      bus.cm_done = tbl[i][5]; bus.cd_hart_id = tbl[i][4:3];
      bus.cache_miss = tbl[i][2]; bus.cm_hart_id = tbl[i][1:0];
      @(negedge clk);
    end
    bus.stall = 0; bus.cm_done = 0; bus.cache_miss = 0;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
